// File: rtl/clock_pkg.sv
// Shared constants and helpers for the alarm-clock datapath.
// Field widths, wrap limits and BCD digit-pair conversion.
package clock_pkg;

    localparam int TIME_W = 6;
    localparam int BCD_W  = 4;

    localparam logic [TIME_W-1:0] MAX_HOUR = 6'd23;
    localparam logic [TIME_W-1:0] MAX_MIN  = 6'd59;
    localparam logic [TIME_W-1:0] MAX_SEC  = 6'd59;

    // Two BCD digits to binary; 8 bits so out-of-range digits stay visible.
    function automatic logic [7:0] bcd2_to_bin(
        input logic [BCD_W-1:0] tens,
        input logic [BCD_W-1:0] units
    );
        return 8'(tens) * 8'd10 + 8'(units);
    endfunction

endpackage

// File: rtl/clock_time_counter_sec_tick_gen.sv
// One-second prescaler: counts 0..TICKS_PER_SEC-1 and flags the last count.
// A synchronous clear restarts the second from zero.
module sec_tick_gen #(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICKS_PER_SEC - 1);

    logic [15:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/clock_time_counter.sv
// 24-hour time-of-day counter with BCD preset and prescaled second tick.
// Hours, minutes and seconds are kept as registered binary values.
module clock_time_counter
    import clock_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        H_in1,
    input  logic [BCD_W-1:0]  H_in0,
    input  logic [BCD_W-1:0]  M_in1,
    input  logic [BCD_W-1:0]  M_in0,
    input  logic              LD_time,
    output logic [TIME_W-1:0] tmp_hour,
    output logic [TIME_W-1:0] tmp_minute,
    output logic [TIME_W-1:0] tmp_second
);

    logic [7:0]        load_hour;
    logic [7:0]        load_min;
    logic              load_ok;
    logic              tick;
    logic              sec_wrap;
    logic              min_carry;
    logic [TIME_W-1:0] hour_n;
    logic [TIME_W-1:0] min_n;
    logic [TIME_W-1:0] sec_n;

    assign load_hour = bcd2_to_bin({2'b00, H_in1}, H_in0);
    assign load_min  = bcd2_to_bin(M_in1, M_in0);

    assign load_ok = LD_time
                  && (H_in0 <= 4'd9)
                  && (M_in1 <= 4'd5)
                  && (M_in0 <= 4'd9)
                  && (load_hour <= 8'd23);

    sec_tick_gen #(
        .TICKS_PER_SEC (TICKS_PER_SEC)
    ) u_sec_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (load_ok),
        .tick  (tick)
    );

    // Out-of-range fields collapse to 0 and carry, exactly like a wrap.
    always_comb begin
        sec_n     = tmp_second + 6'd1;
        min_n     = tmp_minute;
        hour_n    = tmp_hour;
        sec_wrap  = (tmp_second >= MAX_SEC);
        min_carry = (tmp_minute > MAX_MIN)
                 || (sec_wrap && tmp_minute == MAX_MIN);

        if (sec_wrap) begin
            sec_n = '0;
        end

        if (tmp_minute > MAX_MIN) begin
            min_n = '0;
        end else if (sec_wrap) begin
            min_n = (tmp_minute == MAX_MIN) ? '0 : tmp_minute + 6'd1;
        end

        if (tmp_hour > MAX_HOUR) begin
            hour_n = '0;
        end else if (min_carry) begin
            hour_n = (tmp_hour == MAX_HOUR) ? '0 : tmp_hour + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmp_hour   <= '0;
            tmp_minute <= '0;
            tmp_second <= '0;
        end else if (load_ok) begin
            tmp_hour   <= load_hour[TIME_W-1:0];
            tmp_minute <= load_min[TIME_W-1:0];
            tmp_second <= '0;
        end else if (tick) begin
            tmp_hour   <= hour_n;
            tmp_minute <= min_n;
            tmp_second <= sec_n;
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// Scoreboard bench for clock_time_counter against a seconds-of-day model.
// Driver pushes expected time per edge; monitor pops and compares.
module tb_clock_time_counter;

    localparam int TPS = 10;
    localparam int DAY = 86400;

    logic       clk;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic [5:0] tmp_hour;
    logic [5:0] tmp_minute;
    logic [5:0] tmp_second;

    int n_checks = 0;
    int n_fail   = 0;
    int t_ref    = 0;
    int pc_ref   = 0;
    int exp_q[$];

    clock_time_counter #(
        .TICKS_PER_SEC (TPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .tmp_hour   (tmp_hour),
        .tmp_minute (tmp_minute),
        .tmp_second (tmp_second)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_time(input string name, input int exp_t);
        int eh, em, es;
        eh = exp_t / 3600;
        em = (exp_t / 60) % 60;
        es = exp_t % 60;
        n_checks++;
        if (int'(tmp_hour) != eh || int'(tmp_minute) != em
            || int'(tmp_second) != es) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d:%0d:%0d expected %0d:%0d:%0d",
                     name, $time, tmp_hour, tmp_minute, tmp_second,
                     eh, em, es);
        end
    endtask

    // Time as seconds since midnight; pc counts edges since the last second.
    task automatic model_step(input logic r, input logic ld,
                              input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0);
        int lh, lm;
        if (!r) begin
            t_ref  = 0;
            pc_ref = 0;
        end else begin
            lh = int'(h1) * 10 + int'(h0);
            lm = int'(m1) * 10 + int'(m0);
            if (ld && h0 <= 9 && m1 <= 5 && m0 <= 9 && lh <= 23) begin
                t_ref  = lh * 3600 + lm * 60;
                pc_ref = 0;
            end else begin
                pc_ref++;
                if (pc_ref == TPS) begin
                    pc_ref = 0;
                    t_ref  = (t_ref + 1) % DAY;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic ld,
                         input logic [1:0] h1, input logic [3:0] h0,
                         input logic [3:0] m1, input logic [3:0] m0);
        @(negedge clk);
        reset   = r;
        LD_time = ld;
        H_in1   = h1;
        H_in0   = h0;
        M_in1   = m1;
        M_in0   = m0;
        model_step(r, ld, h1, h0, m1, m0);
        exp_q.push_back(t_ref);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, 2'($urandom_range(0, 3)),
                         4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)));
    endtask

    // Short reset pulse entirely between two rising edges.
    task automatic async_pulse();
        @(negedge clk);
        LD_time = 1'b0;
        #1 reset = 1'b0;
        #1 chk_time("async_reset", 0);
        reset = 1'b1;
        t_ref  = 0;
        pc_ref = 0;
        model_step(1'b1, 1'b0, H_in1, H_in0, M_in1, M_in0);
        exp_q.push_back(t_ref);
    endtask

    initial begin : monitor
        int e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_time("time", e);
            end
        end
    end

    initial begin : stim
        logic       r, ld;
        logic [1:0] h1;
        logic [3:0] h0, m1, m0;
        reset   = 1'b0;
        LD_time = 1'b0;
        H_in1   = 2'($urandom_range(0, 3));
        H_in0   = 4'($urandom_range(0, 15));
        M_in1   = 4'($urandom_range(0, 15));
        M_in0   = 4'($urandom_range(0, 15));
        #1 chk_time("reset_imm", 0);

        repeat (10) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)),
                          4'($urandom_range(0, 15)));

        repeat (20) drive(1'b1, 1'b1, 2'd0, 4'd1, 4'd2, 4'd0);
        idle(610);

        repeat (3) drive(1'b1, 1'b1, 2'd2, 4'd4, 4'd0, 4'd0);
        repeat (3) drive(1'b1, 1'b1, 2'd0, 4'd1, 4'd6, 4'd0);
        repeat (3) drive(1'b1, 1'b1, 2'd0, 4'd1, 4'd0, 4'd10);
        repeat (3) drive(1'b1, 1'b1, 2'd2, 4'd9, 4'd0, 4'd0);
        idle(30);

        drive(1'b1, 1'b1, 2'd2, 4'd3, 4'd5, 4'd9);
        idle(610);

        drive(1'b1, 1'b1, 2'd1, 4'd2, 4'd3, 4'd4);
        idle(9);
        drive(1'b1, 1'b1, 2'd1, 4'd2, 4'd3, 4'd4);
        idle(12);

        drive(1'b1, 1'b1, 2'd0, 4'd5, 4'd3, 4'd0);
        idle(175);
        async_pulse();
        idle(25);

        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) begin
                async_pulse();
            end else begin
                r  = ($urandom_range(0, 199) != 0);
                ld = ($urandom_range(0, 24) == 0);
                if ($urandom_range(0, 1) == 1) begin
                    h1 = 2'($urandom_range(0, 2));
                    h0 = 4'($urandom_range(0, 9));
                    m1 = 4'($urandom_range(0, 5));
                    m0 = 4'($urandom_range(0, 9));
                end else begin
                    h1 = 2'($urandom_range(0, 3));
                    h0 = 4'($urandom_range(0, 15));
                    m1 = 4'($urandom_range(0, 15));
                    m0 = 4'($urandom_range(0, 15));
                end
                drive(r, ld, h1, h0, m1, m0);
            end
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
